chord_voice_mixer: RTL and testbench

//  N-voice chord engine between song_reader and codec_conditioner. Allocates incoming notes to free voices,

---
 rtl/chord_voice_mixer_pkg.sv | 11 +
 rtl/chord_voice_mixer_alloc.sv | 74 +++++++
 rtl/chord_voice_mixer.sv | 141 ++++++++++++++
 tb/tb_chord_voice_mixer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/chord_voice_mixer_pkg.sv
// Shared types for the chord voice mixer: mixer FSM state encoding.
package chord_voice_mixer_pkg;

   typedef enum logic [1:0] {
      MIX_IDLE    = 2'd0,
      MIX_COLLECT = 2'd1,
      MIX_SUM     = 2'd2,
      MIX_OUT     = 2'd3
   } mix_state_t;

endpackage

// File: rtl/chord_voice_mixer_alloc.sv
// Voice allocator: lowest-free-voice priority encoder, per-voice beat
// countdown, and the voice_note / voice_active registers.
module chord_voice_mixer_alloc #(
   parameter int NUM_VOICES = 3,
   parameter int NOTE_W     = 6,
   parameter int DUR_W      = 6
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         play_enable,
   input  logic                         load_new_note,
   input  logic [NOTE_W-1:0]            note_to_load,
   input  logic [DUR_W-1:0]             duration_to_load,
   input  logic                         beat,
   output logic                         load_accepted,
   output logic                         load_rejected,
   output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
   output logic [NUM_VOICES-1:0]        voice_active
);

   logic [NUM_VOICES-1:0] free_mask;
   logic [NUM_VOICES-1:0] sel_onehot;
   logic [DUR_W-1:0]      remaining [NUM_VOICES];
   logic                  found;
   logic                  accept;
   logic                  reject;
   logic                  tick;

   // Free mask comes from the registered state, so a voice expiring on this
   // edge is still seen as busy and cannot be reloaded in the same cycle.
   always_comb begin
      free_mask  = ~voice_active;
      sel_onehot = '0;
      found      = 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (free_mask[i] && !found) begin
            sel_onehot[i] = 1'b1;
            found         = 1'b1;
         end
      end
      accept = load_new_note && (duration_to_load != '0) && (|free_mask);
      reject = load_new_note && !accept;
      tick   = beat && play_enable;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load_accepted <= 1'b0;
         load_rejected <= 1'b0;
         voice_active  <= '0;
         voice_note    <= '0;
         for (int i = 0; i < NUM_VOICES; i++) remaining[i] <= '0;
      end else begin
         load_accepted <= accept;
         load_rejected <= reject;
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (accept && sel_onehot[i]) begin
               voice_active[i]                 <= 1'b1;
               voice_note[i*NOTE_W +: NOTE_W]  <= note_to_load;
               remaining[i]                    <= duration_to_load;
            end else if (tick && voice_active[i]) begin
               if (remaining[i] == DUR_W'(1)) begin
                  voice_active[i]                <= 1'b0;
                  voice_note[i*NOTE_W +: NOTE_W] <= '0;
                  remaining[i]                   <= '0;
               end else begin
                  remaining[i] <= remaining[i] - 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/chord_voice_mixer.sv
// N-voice chord engine: allocates notes to voices and mixes the per-voice
// samples into one scaled, saturated sample per request.
module chord_voice_mixer
   import chord_voice_mixer_pkg::*;
#(
   parameter int NUM_VOICES = 3,
   parameter int SAMPLE_W   = 16,
   parameter int NOTE_W     = 6,
   parameter int DUR_W      = 6,
   parameter int MIX_SHIFT  = 2,
   parameter int TIMEOUT    = 255
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           play_enable,
   input  logic                           load_new_note,
   input  logic [NOTE_W-1:0]              note_to_load,
   input  logic [DUR_W-1:0]               duration_to_load,
   output logic                           load_accepted,
   output logic                           load_rejected,
   input  logic                           beat,
   input  logic                           generate_next_sample,
   output logic [NUM_VOICES*NOTE_W-1:0]   voice_note,
   output logic [NUM_VOICES-1:0]          voice_active,
   input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
   input  logic [NUM_VOICES-1:0]          voice_sample_ready,
   output logic [SAMPLE_W-1:0]            mix_sample,
   output logic                           mix_ready,
   output logic                           sample_overrun,
   output logic                           all_done,
   output logic [1:0]                     mix_state
);

   localparam int AW = SAMPLE_W + $clog2(NUM_VOICES) + 1;
   localparam int IW = $clog2(NUM_VOICES);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic signed [AW-1:0] SAT_MAX = AW'((1 <<< (SAMPLE_W-1)) - 1);
   localparam logic signed [AW-1:0] SAT_MIN = AW'(-(1 <<< (SAMPLE_W-1)));

   mix_state_t                  state, state_next;
   logic [NUM_VOICES-1:0]       got;
   logic signed [SAMPLE_W-1:0]  cap [NUM_VOICES];
   logic [TW-1:0]               timer;
   logic [IW-1:0]               idx;
   logic signed [AW-1:0]        acc, acc_next, shifted;
   logic [SAMPLE_W-1:0]         sat_val;
   logic                        all_got, timed_out, last_voice;

   chord_voice_mixer_alloc #(
      .NUM_VOICES (NUM_VOICES),
      .NOTE_W     (NOTE_W),
      .DUR_W      (DUR_W)
   ) u_alloc (
      .clk              (clk),
      .rst              (reset),
      .play_enable      (play_enable),
      .load_new_note    (load_new_note),
      .note_to_load     (note_to_load),
      .duration_to_load (duration_to_load),
      .beat             (beat),
      .load_accepted    (load_accepted),
      .load_rejected    (load_rejected),
      .voice_note       (voice_note),
      .voice_active     (voice_active)
   );

   assign all_done  = ~|voice_active;
   assign mix_state = state;

   // voice_sample_ready[i] is a valid-only strobe: voice_sample[i] is taken in
   // the cycle it is high during COLLECT; there is no ready back to note_player.
   always_comb begin
      state_next = state;
      all_got    = &(got | voice_sample_ready | ~voice_active);
      timed_out  = (timer == TW'(TIMEOUT));
      last_voice = (idx == IW'(NUM_VOICES - 1));
      acc_next   = acc + AW'(cap[idx]);
      shifted    = acc_next >>> MIX_SHIFT;
      if (shifted > SAT_MAX)      sat_val = SAT_MAX[SAMPLE_W-1:0];
      else if (shifted < SAT_MIN) sat_val = SAT_MIN[SAMPLE_W-1:0];
      else                        sat_val = shifted[SAMPLE_W-1:0];
      case (state)
         MIX_IDLE:    if (generate_next_sample) state_next = MIX_COLLECT;
         MIX_COLLECT: if (all_got || timed_out) state_next = MIX_SUM;
         MIX_SUM:     if (last_voice) state_next = MIX_OUT;
         MIX_OUT:     state_next = MIX_IDLE;
         default:     state_next = MIX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= MIX_IDLE;
         got            <= '0;
         timer          <= '0;
         idx            <= '0;
         acc            <= '0;
         mix_sample     <= '0;
         mix_ready      <= 1'b0;
         sample_overrun <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) cap[i] <= '0;
      end else begin
         state          <= state_next;
         mix_ready      <= 1'b0;
         sample_overrun <= generate_next_sample && (state != MIX_IDLE);
         case (state)
            MIX_IDLE: begin
               if (generate_next_sample) begin
                  got   <= '0;
                  timer <= '0;
                  for (int i = 0; i < NUM_VOICES; i++) cap[i] <= '0;
               end
            end
            MIX_COLLECT: begin
               if (!timed_out) timer <= timer + 1'b1;
               for (int i = 0; i < NUM_VOICES; i++) begin
                  if (voice_sample_ready[i] && !got[i]) begin
                     cap[i] <= voice_sample[i*SAMPLE_W +: SAMPLE_W];
                     got[i] <= 1'b1;
                  end
               end
               if (all_got || timed_out) begin
                  acc <= '0;
                  idx <= '0;
               end
            end
            MIX_SUM: begin
               acc <= acc_next;
               idx <= idx + 1'b1;
               // Result registered on the last add so mix_ready is visible in OUT.
               if (last_voice) begin
                  mix_sample <= sat_val;
                  mix_ready  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_chord_voice_mixer.sv
// Directed bench for chord_voice_mixer: two instances (MIX_SHIFT 2 and 0)
// share all stimulus; mix results are checked from expected queues.
module tb_chord_voice_mixer;

  localparam int NV = 3;
  localparam int SW = 16;
  localparam int NW = 6;
  localparam int DW = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            play_enable, load_new_note, beat, generate_next_sample;
  logic [NW-1:0]   note_to_load;
  logic [DW-1:0]   duration_to_load;
  logic [NV*SW-1:0] voice_sample;
  logic [NV-1:0]   voice_sample_ready;

  logic            load_accepted, load_rejected, mix_ready, sample_overrun, all_done;
  logic [NV*NW-1:0] voice_note;
  logic [NV-1:0]   voice_active;
  logic [SW-1:0]   mix_sample;
  logic [1:0]      mix_state;

  logic            ns_load_accepted, ns_load_rejected, ns_mix_ready, ns_sample_overrun, ns_all_done;
  logic [NV*NW-1:0] ns_voice_note;
  logic [NV-1:0]   ns_voice_active;
  logic [SW-1:0]   ns_mix_sample;
  logic [1:0]      ns_mix_state;

  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] exp_ns_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int lat;

  chord_voice_mixer #(.NUM_VOICES(NV), .SAMPLE_W(SW), .NOTE_W(NW), .DUR_W(DW),
                      .MIX_SHIFT(2), .TIMEOUT(255)) dut (
    .clk(clk), .reset(rst), .play_enable(play_enable), .load_new_note(load_new_note),
    .note_to_load(note_to_load), .duration_to_load(duration_to_load),
    .load_accepted(load_accepted), .load_rejected(load_rejected), .beat(beat),
    .generate_next_sample(generate_next_sample), .voice_note(voice_note),
    .voice_active(voice_active), .voice_sample(voice_sample),
    .voice_sample_ready(voice_sample_ready), .mix_sample(mix_sample),
    .mix_ready(mix_ready), .sample_overrun(sample_overrun), .all_done(all_done),
    .mix_state(mix_state));

  chord_voice_mixer #(.NUM_VOICES(NV), .SAMPLE_W(SW), .NOTE_W(NW), .DUR_W(DW),
                      .MIX_SHIFT(0), .TIMEOUT(255)) dut_ns (
    .clk(clk), .reset(rst), .play_enable(play_enable), .load_new_note(load_new_note),
    .note_to_load(note_to_load), .duration_to_load(duration_to_load),
    .load_accepted(ns_load_accepted), .load_rejected(ns_load_rejected), .beat(beat),
    .generate_next_sample(generate_next_sample), .voice_note(ns_voice_note),
    .voice_active(ns_voice_active), .voice_sample(voice_sample),
    .voice_sample_ready(voice_sample_ready), .mix_sample(ns_mix_sample),
    .mix_ready(ns_mix_ready), .sample_overrun(ns_sample_overrun), .all_done(ns_all_done),
    .mix_state(ns_mix_state));

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
  endtask

  // driver tasks
  task automatic load(input logic [NW-1:0] n, input logic [DW-1:0] d);
    load_new_note = 1'b1; note_to_load = n; duration_to_load = d;
    tick();
    load_new_note = 1'b0;
  endtask

  task automatic pulse_beat();
    beat = 1'b1; tick(); beat = 1'b0;
  endtask

  task automatic request();
    generate_next_sample = 1'b1; tick(); generate_next_sample = 1'b0;
  endtask

  task automatic ready(input logic [NV-1:0] m);
    voice_sample_ready = m; tick(); voice_sample_ready = '0;
  endtask

  // scoreboard: wait (bounded) for mix_ready, then compare with queued expectations
  task automatic wait_mix(input int bound, output int latency);
    logic [SW-1:0] e, ens;
    latency = 1;
    while (!mix_ready && latency < bound) begin
      tick();
      latency++;
    end
    e   = exp_q.pop_front();
    ens = exp_ns_q.pop_front();
    check("mix_ready_seen", mix_ready, 1'b1);
    check("mix_sample", mix_sample, e);
    check("mix_sample_noshift", ns_mix_sample, ens);
    check("mix_ready_noshift", ns_mix_ready, 1'b1);
    tick();
    check("mix_ready_pulse", mix_ready, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    play_enable = 1'b0; load_new_note = 1'b0; beat = 1'b0; generate_next_sample = 1'b0;
    note_to_load = '0; duration_to_load = '0; voice_sample = '0; voice_sample_ready = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_active", voice_active, 3'b000);
    check("rst_note", voice_note, '0);
    check("rst_all_done", all_done, 1'b1);
    check("rst_mix", mix_sample, 16'h0000);
    check("rst_state", mix_state, 2'd0);

    // allocation order and rejection when full
    load(6'd10, 6'd2); check("ld1_acc", load_accepted, 1'b1); check("ld1_act", voice_active, 3'b001);
    load(6'd20, 6'd2); check("ld2_acc", load_accepted, 1'b1); check("ld2_act", voice_active, 3'b011);
    load(6'd30, 6'd2); check("ld3_acc", load_accepted, 1'b1); check("ld3_act", voice_active, 3'b111);
    load(6'd40, 6'd2); check("ld4_rej", load_rejected, 1'b1); check("ld4_acc", load_accepted, 1'b0);
    check("ld4_notes", voice_note, {6'd30, 6'd20, 6'd10});
    tick();
    check("rej_pulse", load_rejected, 1'b0);

    // countdown: frozen without play_enable, expires after 2 beats
    pulse_beat(); check("beat_frozen", voice_active, 3'b111);
    play_enable = 1'b1;
    pulse_beat(); check("beat1_act", voice_active, 3'b111);
    pulse_beat(); check("beat2_act", voice_active, 3'b000);
    check("beat2_done", all_done, 1'b1);
    check("beat2_notes", voice_note, '0);
    load(6'd7, 6'd0); check("dur0_rej", load_rejected, 1'b1); check("dur0_act", voice_active, 3'b000);
    play_enable = 1'b0;

    // three 0x1000 samples on separate cycles
    load(6'd1, 6'd5); load(6'd2, 6'd5); load(6'd3, 6'd5);
    check("reload_act", voice_active, 3'b111);
    voice_sample = {16'h1000, 16'h1000, 16'h1000};
    request(); check("collect_state", mix_state, 2'd1);
    ready(3'b001); tick(); ready(3'b010); tick(); ready(3'b100);
    exp_q.push_back(16'h0C00); exp_ns_q.push_back(16'h3000);
    wait_mix(50, lat);
    check("mix_latency", lat, NV + 1);

    // saturation
    voice_sample = {16'h7FFF, 16'h7FFF, 16'h7FFF};
    request(); ready(3'b111);
    exp_q.push_back(16'h5FFF); exp_ns_q.push_back(16'h7FFF);
    wait_mix(50, lat);
    voice_sample = {16'h8000, 16'h8000, 16'h8000};
    request(); ready(3'b111);
    exp_q.push_back(16'hA000); exp_ns_q.push_back(16'h8000);
    wait_mix(50, lat);

    // voice 1 silent: timeout path, plus an overrun request
    voice_sample = {16'h2000, 16'h7777, 16'h1000};
    request(); ready(3'b101);
    request(); check("overrun", sample_overrun, 1'b1);
    tick(); check("overrun_pulse", sample_overrun, 1'b0);
    check("still_collect", mix_state, 2'd1);
    exp_q.push_back(16'h0C00); exp_ns_q.push_back(16'h3000);
    wait_mix(400, lat);

    // async reset mid-SUM, then a clean mix
    voice_sample = {16'h1000, 16'h1000, 16'h1000};
    request(); ready(3'b111); tick();
    check("in_sum", mix_state, 2'd2);
    #1 rst = 1'b1;
    #1;
    check("arst_state", mix_state, 2'd0);
    check("arst_mix", mix_sample, 16'h0000);
    check("arst_act", voice_active, 3'b000);
    check("arst_done", all_done, 1'b1);
    tick();
    rst = 1'b0;
    load(6'd5, 6'd3); check("post_rst_acc", load_accepted, 1'b1);
    voice_sample = {16'h0000, 16'h0000, 16'h0400};
    request(); ready(3'b001);
    exp_q.push_back(16'h0100); exp_ns_q.push_back(16'h0400);
    wait_mix(50, lat);
    check("post_rst_latency", lat, NV + 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
